// File: rtl/nx1_opm_wr_sched.sv
// nx1_opm_wr_sched: YM2151 write scheduler and status front-end for the X1 FM board (I/O 0700-0703).
// Optional sticky FIFO-overflow status bit at O_D[6]: define NX1_OPM_OVF_FLAG_EN.
module nx1_opm_wr_sched #(
    parameter int FIFO_AW = 2,
    parameter int WR_GAP  = 64
) (
    input  logic       I_CLK,
    input  logic       I_RESET,
    input  logic       I_CS,
    input  logic       I_A,
    input  logic       I_WR,
    input  logic       I_RD,
    input  logic [7:0] I_D,
    output logic [7:0] O_D,
    output logic       O_DOE,
    input  logic [1:0] I_OPM_FLAG,
    output logic [7:0] O_OPM_A,
    output logic [7:0] O_OPM_D,
    output logic       O_OPM_WE,
    output logic       O_BUSY,
    output logic       O_FULL
);

    localparam int               DEPTH     = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] DEPTH_CNT = (FIFO_AW + 1)'(DEPTH);
    localparam logic [7:0]       GAP_LOAD  = 8'(WR_GAP);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_GAP
    } state_t;

    state_t state_reg, state_next;

    logic [15:0]        mem_reg [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [FIFO_AW:0]   count_reg, count_next;
    logic [7:0]         latch_reg;
    logic [7:0]         gap_cnt_reg;
    logic [7:0]         opm_a_reg, opm_d_reg;
    logic [7:0]         od_reg;
    logic               wr_d_reg;
    logic               we_reg, busy_reg, doe_reg;
    logic               wr_act, wr_edge, rd_act;
    logic               push, pop, issue, fifo_full, ovf_bit;

    assign wr_act    = I_CS & I_WR;
    assign wr_edge   = wr_act & ~wr_d_reg;
    assign rd_act    = I_CS & I_RD;
    assign fifo_full = (count_reg == DEPTH_CNT);
    // Full is judged on the pre-pop count, so a write landing in an ISSUE cycle is still dropped.
    assign push      = wr_edge & I_A & ~fifo_full;

    assign count_next = count_reg + (FIFO_AW + 1)'(push) - (FIFO_AW + 1)'(pop);

    always_comb begin
        state_next = state_reg;
        issue      = 1'b0;
        pop        = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (count_reg != '0) begin
                    state_next = ST_ISSUE;
                    issue      = 1'b1;
                end
            end
            ST_ISSUE: begin
                pop        = 1'b1;
                state_next = ST_GAP;
            end
            ST_GAP: begin
                if (gap_cnt_reg == 8'd1) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge I_CLK) begin
        if (I_RESET) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // FIFO storage carries no reset so it maps onto distributed/block RAM.
    always_ff @(posedge I_CLK) begin
        if (push) begin
            mem_reg[wr_ptr_reg] <= {latch_reg, I_D};
        end
    end

    always_ff @(posedge I_CLK) begin
        if (I_RESET) begin
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            count_reg   <= '0;
            latch_reg   <= 8'h00;
            gap_cnt_reg <= 8'h00;
            opm_a_reg   <= 8'h00;
            opm_d_reg   <= 8'h00;
            we_reg      <= 1'b0;
            busy_reg    <= 1'b0;
            doe_reg     <= 1'b0;
            od_reg      <= 8'h00;
            // History starts high so a strobe already asserted at release is ignored.
            wr_d_reg    <= 1'b1;
        end else begin
            wr_d_reg  <= wr_act;
            count_reg <= count_next;
            if (wr_edge & ~I_A) begin
                latch_reg <= I_D;
            end
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            if (issue) begin
                {opm_a_reg, opm_d_reg} <= mem_reg[rd_ptr_reg];
            end
            we_reg <= issue;
            if (state_reg == ST_ISSUE) begin
                gap_cnt_reg <= GAP_LOAD;
            end else if (state_reg == ST_GAP) begin
                gap_cnt_reg <= gap_cnt_reg - 8'd1;
            end
            busy_reg <= (count_next != '0) | (state_reg != ST_IDLE);
            doe_reg  <= rd_act;
            od_reg   <= rd_act ? {busy_reg, ovf_bit, 4'b0000, I_OPM_FLAG} : 8'h00;
        end
    end

`ifdef NX1_OPM_OVF_FLAG_EN
    logic rd_d_reg;
    logic ovf_reg;
    logic drop;

    assign drop    = wr_edge & I_A & fifo_full;
    assign ovf_bit = ovf_reg;

    // A drop in the same cycle as the read-release clear wins, so no overflow is lost.
    always_ff @(posedge I_CLK) begin
        if (I_RESET) begin
            rd_d_reg <= 1'b0;
            ovf_reg  <= 1'b0;
        end else begin
            rd_d_reg <= rd_act;
            if (drop) begin
                ovf_reg <= 1'b1;
            end else if (rd_d_reg & ~rd_act) begin
                ovf_reg <= 1'b0;
            end
        end
    end
`else
    assign ovf_bit = 1'b0;
`endif

    assign O_OPM_A  = opm_a_reg;
    assign O_OPM_D  = opm_d_reg;
    assign O_OPM_WE = we_reg;
    assign O_BUSY   = busy_reg;
    assign O_FULL   = fifo_full;
    assign O_DOE    = doe_reg;
    assign O_D      = od_reg;

endmodule

// File: tb/tb_nx1_opm_wr_sched.sv
// tb_nx1_opm_wr_sched: directed plus randomized checks of nx1_opm_wr_sched against an issue-time model.
// Expected status bit 6 follows NX1_OPM_OVF_FLAG_EN.
module tb_nx1_opm_wr_sched;

    localparam int FIFO_AW = 2;
    localparam int DEPTH   = 1 << FIFO_AW;
    localparam int WR_GAP  = 64;
`ifdef NX1_OPM_OVF_FLAG_EN
    localparam logic OVF_EN = 1'b1;
`else
    localparam logic OVF_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst, cs, a, wr, rd;
    logic [7:0] din;
    logic [1:0] flag;
    logic [7:0] od, opm_a, opm_d;
    logic       doe, opm_we, busy, full;

    always #5 clk = ~clk;

    nx1_opm_wr_sched #(.FIFO_AW(FIFO_AW), .WR_GAP(WR_GAP)) dut (
        .I_CLK      (clk),
        .I_RESET    (rst),
        .I_CS       (cs),
        .I_A        (a),
        .I_WR       (wr),
        .I_RD       (rd),
        .I_D        (din),
        .O_D        (od),
        .O_DOE      (doe),
        .I_OPM_FLAG (flag),
        .O_OPM_A    (opm_a),
        .O_OPM_D    (opm_d),
        .O_OPM_WE   (opm_we),
        .O_BUSY     (busy),
        .O_FULL     (full)
    );

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int pulses      = 0;

    // Model: every accepted write is one entry with its push cycle and its computed issue cycle.
    int         ep[$];
    int         et[$];
    logic [7:0] ea[$];
    logic [7:0] ed[$];
    logic [7:0] m_latch;
    logic       m_wr_prev, m_rd_prev, m_ovf;
    int         m_last_t;
    logic [7:0] x_a, x_d, x_od;
    logic       x_we, x_busy, x_full, x_doe;

    // Busy in cycle c: some entry was pushed by c-1 and had not finished its gap at c-1.
    function automatic logic busy_at(int c);
        for (int i = 0; i < ep.size(); i++) begin
            if (ep[i] <= c - 1 && c - 1 <= et[i] + WR_GAP) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic int count_at(int c);
        int n = 0;
        for (int i = 0; i < ep.size(); i++) begin
            if (ep[i] < c && et[i] >= c) n++;
        end
        return n;
    endfunction

    task automatic model_step();
        int   c;
        int   t;
        logic wr_now, rd_now, wedge, drop, busy_c, ovf_c;
        c = cyc;
        if (rst) begin
            ep.delete(); et.delete(); ea.delete(); ed.delete();
            m_latch = 8'h00; m_wr_prev = 1'b1; m_rd_prev = 1'b0; m_ovf = 1'b0;
            m_last_t = -1000;
            x_a = 8'h00; x_d = 8'h00; x_od = 8'h00;
            x_we = 1'b0; x_busy = 1'b0; x_full = 1'b0; x_doe = 1'b0;
            return;
        end
        while (et.size() > 0 && et[0] + WR_GAP + 2 < c) begin
            void'(ep.pop_front()); void'(et.pop_front());
            void'(ea.pop_front()); void'(ed.pop_front());
        end
        busy_c    = busy_at(c);
        ovf_c     = m_ovf;
        wr_now    = cs & wr;
        wedge     = wr_now & ~m_wr_prev;
        m_wr_prev = wr_now;
        drop      = 1'b0;
        if (wedge && !a) begin
            m_latch = din;
        end else if (wedge && a) begin
            if (count_at(c) == DEPTH) begin
                drop = 1'b1;
            end else begin
                t = (c + 2 > m_last_t + WR_GAP + 2) ? c + 2 : m_last_t + WR_GAP + 2;
                ep.push_back(c); et.push_back(t); ea.push_back(m_latch); ed.push_back(din);
                m_last_t = t;
            end
        end
        rd_now = cs & rd;
        x_doe  = rd_now;
        x_od   = rd_now ? {busy_c, ovf_c & OVF_EN, 4'b0000, flag} : 8'h00;
        if (drop) m_ovf = OVF_EN;
        else if (m_rd_prev && !rd_now) m_ovf = 1'b0;
        m_rd_prev = rd_now;
        x_we = 1'b0;
        for (int i = 0; i < et.size(); i++) begin
            if (et[i] == c + 1) begin
                x_we = 1'b1; x_a = ea[i]; x_d = ed[i];
            end
        end
        x_busy = busy_at(c + 1);
        x_full = (count_at(c + 1) == DEPTH);
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic tick(logic r, logic c_s, logic aa, logic w, logic rr, logic [7:0] dd);
        rst = r; cs = c_s; a = aa; wr = w; rd = rr; din = dd;
        model_step();
        @(posedge clk);
        #1;
        cyc++;
        if (opm_we === 1'b1) pulses++;
        chk("opm_we", 32'(opm_we), 32'(x_we));
        chk("opm_a",  32'(opm_a),  32'(x_a));
        chk("opm_d",  32'(opm_d),  32'(x_d));
        chk("busy",   32'(busy),   32'(x_busy));
        chk("full",   32'(full),   32'(x_full));
        chk("doe",    32'(doe),    32'(x_doe));
        chk("od",     32'(od),     32'(x_od));
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic wr_op(logic aa, logic [7:0] dd, int len);
        for (int i = 0; i < len; i++) tick(1'b0, 1'b1, aa, 1'b1, 1'b0, dd);
        tick(1'b0, 1'b0, aa, 1'b0, 1'b0, dd);
    endtask

    int p0;
    int op;

    initial begin
        flag = 2'b00;
        // Reset three cycles with a data-write strobe held across release.
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h55);
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h55);
        idle(5);
        chk("no_push_across_reset", 32'(pulses), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);

        // Single write.
        p0 = pulses;
        wr_op(1'b0, 8'h20, 2);
        wr_op(1'b1, 8'hC7, 3);
        idle(70);
        chk("single_pulses", 32'(pulses - p0), 32'd1);
        chk("single_a", 32'(opm_a), 32'h20);
        chk("single_d", 32'(opm_d), 32'hC7);

        // Burst of three to one register.
        p0 = pulses;
        wr_op(1'b0, 8'h08, 1);
        wr_op(1'b1, 8'h01, 1);
        wr_op(1'b1, 8'h02, 1);
        wr_op(1'b1, 8'h03, 1);
        idle(3 * (WR_GAP + 2) + 10);
        chk("burst_pulses", 32'(pulses - p0), 32'd3);
        chk("burst_a", 32'(opm_a), 32'h08);
        chk("burst_d", 32'(opm_d), 32'h03);

        // Overflow: six writes, one dropped.
        p0 = pulses;
        wr_op(1'b0, 8'h11, 1);
        for (int i = 0; i < 6; i++) wr_op(1'b1, 8'(8'hA0 + i), 1);
        tick(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h00);
        chk("ovf_read1_bit6", 32'(od[6]), 32'(OVF_EN));
        tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00);
        chk("ovf_read2_bit6", 32'(od[6]), 32'd0);
        tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        idle(5 * (WR_GAP + 2) + 10);
        chk("ovf_pulses", 32'(pulses - p0), 32'd5);

        // Status flags while busy and while idle.
        flag = 2'b10;
        wr_op(1'b1, 8'h5A, 1);
        tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00);
        chk("status_busy", 32'(od), 32'h82);
        chk("status_busy_doe", 32'(doe), 32'd1);
        tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        idle(WR_GAP + 10);
        tick(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h00);
        chk("status_idle", 32'(od), 32'h02);
        tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        flag = 2'b00;

        // Reset while in GAP with three entries queued.
        wr_op(1'b0, 8'h33, 1);
        for (int i = 0; i < 4; i++) wr_op(1'b1, 8'(8'h70 + i), 1);
        idle(10);
        tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        p0 = pulses;
        idle(4 * (WR_GAP + 2));
        chk("reset_mid_pulses", 32'(pulses - p0), 32'd0);
        chk("reset_mid_busy", 32'(busy), 32'd0);
        wr_op(1'b1, 8'h44, 1);
        idle(5);
        chk("fresh_latch_a", 32'(opm_a), 32'h00);
        chk("fresh_latch_d", 32'(opm_d), 32'h44);

        // Randomized traffic.
        for (int k = 0; k < 700; k++) begin
            op   = $urandom_range(0, 19);
            flag = 2'($urandom_range(0, 3));
            if (op == 0) begin
                tick(1'b1, 1'($urandom_range(0, 1)), 1'b1, 1'($urandom_range(0, 1)), 1'b0, 8'h00);
            end else if (op <= 4) begin
                wr_op(1'b0, 8'($urandom), $urandom_range(1, 3));
            end else if (op <= 11) begin
                wr_op(1'b1, 8'($urandom), $urandom_range(1, 3));
            end else if (op <= 13) begin
                for (int i = 0; i < $urandom_range(1, 2); i++)
                    tick(1'b0, 1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b1, 8'h00);
                tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
            end else if (op == 14) begin
                tick(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'($urandom));
            end else begin
                idle($urandom_range(1, 30));
            end
        end
        idle(6 * (WR_GAP + 2));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/nx1_opm_wr_sched.md
Name: nx1_opm_wr_sched

Overview:
- Write scheduler and status front-end for the X1 FM board OPM (YM2151) at I/O 0700-0703.
- Captures Z80 address and data writes from the slot bus and queues {reg, data} pairs in a small FIFO.
- Issues queued pairs to the OPM core at a fixed minimum spacing, emulating the OPM write-busy time.
- Serves the status read with the emulated busy flag; replaces the dummy status path in the FM slot top.

Parameters:
- FIFO_AW, 2, FIFO address width; depth = 2**FIFO_AW entries (default 4).
- WR_GAP, 64, idle clocks after each OPM write pulse before the next may issue; legal range 1..255.

Ports:
- I_CLK  in  1  system clock; all logic on the rising edge.
- I_RESET  in  1  synchronous reset, active high.
- I_CS  in  1  decoded OPM select (0700-0703), level.
- I_A  in  1  slot_addr[0]: 0 = register-address port, 1 = data port.
- I_WR  in  1  write strobe, active high level (inverted #wr).
- I_RD  in  1  read strobe, active high level (inverted #rd).
- I_D  in  8  write data from Z80.
- O_D  out  8  status read data.
- O_DOE  out  1  read data valid.
- I_OPM_FLAG  in  2  timer B/A overflow flags from OPM core ([1]=B, [0]=A).
- O_OPM_A  out  8  OPM register address for the current issue.
- O_OPM_D  out  8  OPM register data for the current issue.
- O_OPM_WE  out  1  one-cycle OPM write pulse.
- O_BUSY  out  1  FIFO non-empty or sequencer not IDLE.
- O_FULL  out  1  FIFO holds 2**FIFO_AW entries.

Behaviour:
- Reset values: O_OPM_A=00, O_OPM_D=00, O_OPM_WE=0, O_BUSY=0, O_FULL=0, O_DOE=0, O_D=00.
- Reset state: address latch=00, FIFO empty, FSM=IDLE. Strobe-history register resets to 1, so a strobe held across reset release is not taken as a write.
- Write edge: wr_edge = I_CS & I_WR & ~wr_d, where wr_d is I_CS & I_WR registered. Exactly one event per Z80 write cycle regardless of strobe length.
- Address write (I_A=0) on wr_edge: address latch <= I_D at the end of that cycle; no FIFO activity.
- Data write (I_A=1) on wr_edge: push {latch, I_D} at the end of that cycle. The latch is unchanged, so repeated data writes reuse the same register.
- Same-cycle address latch update cannot occur alongside a push; pushes always use the latch value from before the edge.
- Full: push is evaluated against the count before any same-cycle pop. A data write while count==depth is dropped, and FIFO contents are unchanged.
- Empty: no pop while empty; O_OPM_WE stays 0.
- Pointers wrap modulo depth. Count is FIFO_AW+1 bits wide.
- FSM IDLE: if count!=0, go to ISSUE.
- FSM ISSUE (1 cycle): O_OPM_WE=1, with O_OPM_A/O_OPM_D = FIFO head registered on the IDLE->ISSUE transition; pop at the end of the cycle; load gap counter with WR_GAP; go to GAP.
- FSM GAP: decrement the counter each cycle; on reaching 1, go to IDLE.
- Timing: a data write edge in cycle n into an idle, empty block gives O_OPM_WE=1 in cycle n+2.
- Back-to-back issue spacing is exactly WR_GAP+2 cycles.
- O_OPM_A/O_OPM_D hold their last issued values between pulses.
- O_BUSY = (count!=0) | (state!=IDLE), registered; it falls in the cycle after the last GAP->IDLE transition when the FIFO is empty.
- Status read: O_DOE = I_CS & I_RD & I_A==... Status reads are accepted on either port address.
- Status read data: O_D = {O_BUSY, ovf, 4'b0, I_OPM_FLAG}, registered, one-cycle latency after I_CS & I_RD.
- When not reading, O_D = 00 and O_DOE = 0.
- Reset mid-issue: any FIFO contents and the pending gap are discarded; O_OPM_WE is 0 in the cycle after I_RESET is sampled high.

Optional Feature:
- Macro: NX1_OPM_OVF_FLAG_EN.
- Defined: sticky overflow bit ovf sets on a dropped data write (FIFO full) and appears at O_D[6]. It clears on the cycle after a status read completes (falling I_CS & I_RD) and on reset. A same-cycle drop and clear leaves ovf set.
- Not defined: O_D[6] is always 0; dropped writes are silent.

Test Plan:
- Reset then idle: hold I_RESET 3 cycles -> all outputs 0; I_WR held high across release produces no push and O_OPM_WE stays 0.
- Single write: address write 0x20, then data write 0xC7 at cycle n -> O_OPM_WE=1 in cycle n+2 with O_OPM_A=20, O_OPM_D=C7; O_BUSY high from n+1 until ISSUE+WR_GAP+1.
- Burst spacing: address 0x08, data 0x01,0x02,0x03 back-to-back -> three pulses 66 cycles apart (WR_GAP=64), all O_OPM_A=08, data in order 01,02,03.
- Overflow: six data writes with WR_GAP=64 -> first issued immediately, four queued (O_FULL=1), one dropped. Expect 5 pulses total; with NX1_OPM_OVF_FLAG_EN, a status read returns bit6=1 and the next read returns bit6=0.
- Status: I_OPM_FLAG=2'b10 with the FIFO busy, status read -> O_D=0x82 one cycle after strobe, with O_DOE=1; when idle, O_D=0x02.
- Reset mid-burst: assert I_RESET while in GAP with 3 queued -> no further pulses, O_BUSY=0, and a subsequent data write is issued with a fresh address latch of 00.
